// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern generator shifting a latched pattern MSB-first with repeats and optional gaps
module seq_pattern_tx #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   reps,
  input  logic               abort,
  output logic               x,
  output logic               x_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int GAP_W = 4;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;
  state_t             r_state, w_state;
  logic [MAX_LEN-1:0] r_pat, w_pat, w_sh;
  logic [LEN_W-1:0]   r_len, w_len, r_idx, w_idx;
  logic [REP_W-1:0]   r_reps, w_reps, r_rep, w_rep;
  logic [GAP_W-1:0]   r_gap, w_gap;
  logic               r_x, r_valid, r_busy, r_done, r_err;
  logic               w_x, w_valid, w_busy, w_done, w_err, w_legal;
  assign w_legal = (len != '0) && (len <= MAX_L);
  assign w_sh    = r_pat >> r_idx;
  assign x       = r_x;
  assign x_valid = r_valid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  // next-state, job latching and next registered output values
  always_comb begin
    w_state = r_state;
    w_pat   = r_pat;
    w_len   = r_len;
    w_reps  = r_reps;
    w_idx   = r_idx;
    w_rep   = r_rep;
    w_gap   = r_gap;
    w_x     = 1'b0;
    w_valid = 1'b0;
    w_busy  = r_state != S_IDLE;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_legal) begin
          w_state = S_SHIFT;
          w_pat   = pattern;
          w_len   = len;
          w_reps  = reps;
          w_idx   = len - 1'b1;
          w_rep   = '0;
        end
        w_err = start && !w_legal;
      end
      S_SHIFT: begin
        w_x     = w_sh[0];
        w_valid = 1'b1;
        if (abort) begin
          w_state = S_IDLE;
          w_x     = 1'b0;
          w_valid = 1'b0;
          w_busy  = 1'b0;
        end else if (r_idx != '0) begin
          w_idx = r_idx - 1'b1;
        end else if (r_rep < r_reps) begin
          w_rep = r_rep + 1'b1;
          w_idx = r_len - 1'b1;
          if (GAP > 0) begin
            w_state = S_GAP;
            w_gap   = GAP_W'(GAP - 1);
          end
        end else begin
          w_state = S_DONE;
        end
      end
      S_GAP: begin
        if (abort) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
        end else if (r_gap == '0) begin
          w_state = S_SHIFT;
        end else begin
          w_gap = r_gap - 1'b1;
        end
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end
  // state, job context and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_len   <= '0;
      r_reps  <= '0;
      r_idx   <= '0;
      r_rep   <= '0;
      r_gap   <= '0;
      r_x     <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pat   <= w_pat;
      r_len   <= w_len;
      r_reps  <= w_reps;
      r_idx   <= w_idx;
      r_rep   <= w_rep;
      r_gap   <= w_gap;
      r_x     <= w_x;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed checks of the serial pattern generator with and without repetition gaps
module tb_seq_pattern_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       x0, v0, b0, d0, e0, x2, v2, b2, d2, e2;
  logic [4:0] o0, o2;
  int         n_chk = 0;
  int         n_err = 0;
  assign o0 = {x0, v0, b0, d0, e0};
  assign o2 = {x2, v2, b2, d2, e2};
  always #5 clk = ~clk;
  seq_pattern_tx #(.MAX_LEN(8), .LEN_W(4), .REP_W(4), .GAP(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .abort(abort), .x(x0), .x_valid(v0), .busy(b0), .done(d0), .err(e0));
  seq_pattern_tx #(.MAX_LEN(8), .LEN_W(4), .REP_W(4), .GAP(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .abort(abort), .x(x2), .x_valid(v2), .busy(b2), .done(d2), .err(e2));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_chk++;
    if (o0 !== 5'b00000) begin n_err++; $display("FAIL reset_gap0 got %b exp 00000", o0); end
    n_chk++;
    if (o2 !== 5'b00000) begin n_err++; $display("FAIL reset_gap2 got %b exp 00000", o2); end
  endtask
  task automatic test_single();
    logic [4:0] e [8];
    e = '{5'b00000, 5'b11100, 5'b01100, 5'b11100, 5'b01100, 5'b11100, 5'b00110, 5'b00000};
    do_reset();
    pattern = 8'b0001_0101; len = 4'd5; reps = 4'd0; start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      start = 1'b0;
      n_chk++;
      if (o0 !== e[i]) begin n_err++; $display("FAIL single cyc%0d got %b exp %b", i, o0, e[i]); end
    end
  endtask
  task automatic test_back_to_back();
    logic [4:0] exp;
    do_reset();
    pattern = 8'b0000_1010; len = 4'd4; reps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    n_chk++;
    if (o0 !== 5'b00000) begin n_err++; $display("FAIL b2b_accept got %b exp 00000", o0); end
    for (int i = 0; i < 14; i++) begin
      tick();
      exp = i < 12 ? ((i % 2 == 0) ? 5'b11100 : 5'b01100) : (i == 12 ? 5'b00110 : 5'b00000);
      n_chk++;
      if (o0 !== exp) begin n_err++; $display("FAIL b2b cyc%0d got %b exp %b", i, o0, exp); end
    end
  endtask
  task automatic test_gap();
    logic [4:0] e [10];
    e = '{5'b00000, 5'b11100, 5'b11100, 5'b01100, 5'b00100, 5'b00100,
          5'b11100, 5'b11100, 5'b01100, 5'b00110};
    do_reset();
    pattern = 8'b0000_0110; len = 4'd3; reps = 4'd1; start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      start = 1'b0;
      n_chk++;
      if (o2 !== e[i]) begin n_err++; $display("FAIL gap cyc%0d got %b exp %b", i, o2, e[i]); end
    end
    tick();
    n_chk++;
    if (o2 !== 5'b00000) begin n_err++; $display("FAIL gap_end got %b exp 00000", o2); end
  endtask
  task automatic test_illegal_len();
    do_reset();
    pattern = 8'hFF; reps = 4'd0;
    for (int k = 0; k < 2; k++) begin
      len = k == 0 ? 4'd0 : 4'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_chk++;
      if (o0 !== 5'b00001) begin n_err++; $display("FAIL illegal_err len=%0d got %b exp 00001", len, o0); end
      tick();
      n_chk++;
      if (o0 !== 5'b00000) begin n_err++; $display("FAIL illegal_idle len=%0d got %b exp 00000", len, o0); end
    end
  endtask
  task automatic test_abort_rst();
    logic [4:0] e [5];
    logic [4:0] h [3];
    e = '{5'b00000, 5'b11100, 5'b11100, 5'b00110, 5'b00000};
    h = '{5'b11100, 5'b01100, 5'b11100};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      pattern = 8'hA5; len = 4'd8; reps = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3 - k; i++) begin
        tick();
        n_chk++;
        if (o0 !== h[i]) begin n_err++; $display("FAIL abort%0d head cyc%0d got %b exp %b", k, i, o0, h[i]); end
      end
      pattern = 8'h03; len = 4'd2;
      if (k == 0) abort = 1'b1; else rst = 1'b1;
      tick();
      abort = 1'b0;
      rst = 1'b0;
      n_chk++;
      if (o0 !== 5'b00000) begin n_err++; $display("FAIL abort%0d stop got %b exp 00000", k, o0); end
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick();
        start = 1'b0;
        n_chk++;
        if (o0 !== e[i]) begin n_err++; $display("FAIL abort%0d restart cyc%0d got %b exp %b", k, i, o0, e[i]); end
      end
    end
  endtask
  task automatic test_start_held();
    logic [4:0] e [13];
    e = '{5'b11100, 5'b01100, 5'b11100, 5'b01100, 5'b11100, 5'b00110, 5'b00000,
          5'b11100, 5'b01100, 5'b11100, 5'b01100, 5'b00110, 5'b00000};
    do_reset();
    pattern = 8'b0001_0101; len = 4'd5; reps = 4'd0; start = 1'b1;
    tick();
    n_chk++;
    if (o0 !== 5'b00000) begin n_err++; $display("FAIL held_accept got %b exp 00000", o0); end
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 1) begin pattern = 8'b0000_1010; len = 4'd4; end
      if (i == 6) start = 1'b0;
      n_chk++;
      if (o0 !== e[i]) begin n_err++; $display("FAIL held cyc%0d got %b exp %b", i, o0, e[i]); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_illegal_len();
    test_abort_rst();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
